// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back stage.
//   - rfmux encodings selecting the write-back source
//   - funct3 load codes used by the load extender
//   - bit positions inside the 8-bit WB control word
//   - FSM state type for the float-write hold logic
package wb_pkg;

    // Write-back source select (ctrl_wb[4:2])
    localparam logic [2:0] WB_ALU = 3'd0;
    localparam logic [2:0] WB_MDR = 3'd1;
    localparam logic [2:0] WB_PC4 = 3'd2;
    localparam logic [2:0] WB_CSR = 3'd3;
    localparam logic [2:0] WB_DR  = 3'd4;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // ctrl_wb = {3'b000, rfmux[2:0], rfiwe, rffwe}
    localparam int CTRL_FWE    = 0;
    localparam int CTRL_IWE    = 1;
    localparam int CTRL_MUX_LO = 2;

    typedef enum logic {
        ST_PASS = 1'b0,  // output stage empty or completing this cycle
        ST_HOLD = 1'b1   // float write waiting for the float file
    } wb_state_t;

    function automatic logic [2:0] ctrl_rfmux(input logic [7:0] ctrl);
        return ctrl[CTRL_MUX_LO +: 3];
    endfunction

endpackage

// File: rtl/wb_unit_if.sv
// wb_unit_if: bundles the MEM/WB slot inputs, the two register-file write
// ports, the forwarding tap and the retired-instruction count.
//   slave  : the write-back unit (consumes MEM/WB, drives write ports)
//   master : the pipeline/register-file side
interface wb_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    // MEM/WB slot
    logic            in_valid;
    logic [31:0]     is_din;
    logic [XLEN-1:0] pc_din;
    logic [7:0]      ctrl_wb_din;
    logic [XLEN-1:0] alu_ans_din;
    logic [XLEN-1:0] mdr_din;
    logic [XLEN-1:0] csr_din;
    logic [XLEN-1:0] dr_din;
    logic            wb_stall;
    // Integer file write port
    logic            rf_i_we;
    logic [4:0]      rf_i_addr;
    logic [XLEN-1:0] rf_i_data;
    // Float file write port
    logic            rf_f_we;
    logic [4:0]      rf_f_addr;
    logic [XLEN-1:0] rf_f_data;
    logic            rf_f_ready;
    // Forwarding tap
    logic            fwd_valid;
    logic [4:0]      fwd_addr;
    logic [XLEN-1:0] fwd_data;
    // CSR-visible counter
    logic [CNT_W-1:0] instret;

    modport slave (
        input  in_valid, is_din, pc_din, ctrl_wb_din, alu_ans_din,
               mdr_din, csr_din, dr_din, rf_f_ready,
        output wb_stall, rf_i_we, rf_i_addr, rf_i_data,
               rf_f_we, rf_f_addr, rf_f_data,
               fwd_valid, fwd_addr, fwd_data, instret
    );

    modport master (
        output in_valid, is_din, pc_din, ctrl_wb_din, alu_ans_din,
               mdr_din, csr_din, dr_din, rf_f_ready,
        input  wb_stall, rf_i_we, rf_i_addr, rf_i_data,
               rf_f_we, rf_f_addr, rf_f_data,
               fwd_valid, fwd_addr, fwd_data, instret
    );
endinterface

// File: rtl/wb_unit_load_ext.sv
// load_ext: combinational load extender.
//   mdr    : raw aligned memory word
//   offset : byte offset inside the word (alu_ans[1:0])
//   funct3 : load type
//   data   : extended result
// Halfwords use offset[1] only, so an odd offset silently picks the
// enclosing aligned halfword; misalignment is trapped elsewhere.
import wb_pkg::*;

module load_ext #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mdr,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = mdr[7:0];
            2'd1:    byte_sel = mdr[15:8];
            2'd2:    byte_sel = mdr[23:16];
            default: byte_sel = mdr[31:24];
        endcase
        half_sel = offset[1] ? mdr[31:16] : mdr[15:0];
    end

    always_comb begin
        data = mdr;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   data = mdr;
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = mdr;
        endcase
    end
endmodule

// File: rtl/wb_unit.sv
// wb_unit: write-back stage.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : wb_unit_if.slave -- MEM/WB slot in, integer/float write
//              ports out, forwarding tap, wb_stall, instret
// One register stage (the "output stage") sits between MEM/WB and the
// register files. Integer writes retire in one cycle; a float write is
// held in the output stage until the float file reports ready, stalling
// MEM/WB meanwhile.
import wb_pkg::*;

module wb_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic      clk,
    input  logic      rst,
    wb_unit_if.slave  bus
);
    wb_state_t state, state_nxt;

    logic [4:0]      in_rd;
    logic [2:0]      rfmux;
    logic            in_iwe, in_fwe;
    logic [XLEN-1:0] ld_val, sel_data;
    logic            stall, accept;

    logic            out_vld, out_iwe, out_fwe;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_data;
    logic            f_pend;

    logic [CNT_W-1:0] instret_q;

    logic unused_bits;
    assign unused_bits = ^{bus.ctrl_wb_din[7:5], bus.is_din[31:15], bus.is_din[6:0]};

    assign in_rd  = bus.is_din[11:7];
    assign rfmux  = ctrl_rfmux(bus.ctrl_wb_din);
    assign in_iwe = bus.ctrl_wb_din[CTRL_IWE];
    assign in_fwe = bus.ctrl_wb_din[CTRL_FWE];

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .mdr    (bus.mdr_din),
        .offset (bus.alu_ans_din[1:0]),
        .funct3 (bus.is_din[14:12]),
        .data   (ld_val)
    );

    always_comb begin
        sel_data = '0;
        case (rfmux)
            WB_ALU:  sel_data = bus.alu_ans_din;
            WB_MDR:  sel_data = ld_val;
            WB_PC4:  sel_data = bus.pc_din + XLEN'(4);
            WB_CSR:  sel_data = bus.csr_din;
            WB_DR:   sel_data = bus.dr_din;
            default: sel_data = '0;
        endcase
    end

    assign f_pend = out_vld & out_fwe;

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_PASS;
        else     state <= state_nxt;
    end

    // Stall follows rf_f_ready combinationally so MEM/WB is released the
    // same cycle the float file accepts the pending write.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            ST_PASS: begin
                if (f_pend && !bus.rf_f_ready) begin
                    state_nxt = ST_HOLD;
                    stall     = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.rf_f_ready) state_nxt = ST_PASS;
                else                stall     = 1'b1;
            end
            default: state_nxt = ST_PASS;
        endcase
    end

    assign accept = bus.in_valid & ~stall;

    // Output stage: reloads every non-stalled cycle, so an integer write
    // is visible for exactly one cycle unless a float write holds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_iwe  <= 1'b0;
            out_fwe  <= 1'b0;
            out_rd   <= '0;
            out_data <= '0;
        end else if (!stall) begin
            out_vld  <= bus.in_valid;
            out_iwe  <= bus.in_valid & in_iwe & (in_rd != 5'd0);
            out_fwe  <= bus.in_valid & in_fwe;
            out_rd   <= in_rd;
            out_data <= sel_data;
        end
    end

    // A zeroed instruction word is a squashed slot and does not retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               instret_q <= '0;
        else if (accept && bus.is_din != '0)   instret_q <= instret_q + CNT_W'(1);
    end

    assign bus.wb_stall  = stall;
    // The integer write fires only on the first output-stage cycle; HOLD
    // cycles after it must not repeat it.
    assign bus.rf_i_we   = out_vld & out_iwe & (state == ST_PASS);
    assign bus.rf_i_addr = out_rd;
    assign bus.rf_i_data = out_data;
    assign bus.rf_f_we   = f_pend;
    assign bus.rf_f_addr = out_rd;
    assign bus.rf_f_data = out_data;
    assign bus.fwd_valid = out_vld & (out_iwe | out_fwe);
    assign bus.fwd_addr  = out_rd;
    assign bus.fwd_data  = out_data;
    assign bus.instret   = instret_q;
endmodule
